// File: rtl/lmc_pc_branch.sv
// lmc_pc_branch: LMC program counter with a run/idle/halt FSM and
// accumulator-conditioned branch resolution.
// Optional return stack (call/ret/stack_err) is built when LMC_CALL_STACK_EN is defined.
module lmc_pc_branch #(
   parameter int ADDR_WIDTH  = 4,
   parameter int DATA_WIDTH  = 8,
   parameter int STACK_DEPTH = 4
) (
   input  logic                  timer555,
   input  logic                  reset_n,
   input  logic                  clear,
   input  logic                  run,
   input  logic                  step,
   input  logic                  halt_req,
   input  logic                  jmp,
   input  logic                  z_jmp,
   input  logic                  pz_jmp,
   input  logic [ADDR_WIDTH-1:0] target,
   input  logic [DATA_WIDTH-1:0] acc,
`ifdef LMC_CALL_STACK_EN
   input  logic                  call,
   input  logic                  ret,
   output logic                  stack_err,
`endif
   output logic [ADDR_WIDTH-1:0] pc,
   output logic                  z_flag,
   output logic                  pz_flag,
   output logic                  taken,
   output logic                  wrap,
   output logic                  running,
   output logic                  halted
);

   typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
   logic                    taken_q, taken_d;
   logic                    wrap_q, wrap_d;
   logic [ADDR_WIDTH-1:0]   pc_inc;

`ifdef LMC_CALL_STACK_EN
   localparam int SPW = $clog2(STACK_DEPTH + 1);
   localparam int IW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
   localparam logic [SPW-1:0] FULL = SPW'(STACK_DEPTH);

   logic [ADDR_WIDTH-1:0]   stk_q [STACK_DEPTH];
   logic [ADDR_WIDTH-1:0]   stk_d [STACK_DEPTH];
   logic [SPW-1:0]          sp_q, sp_d, sp_m1;
   logic                    err_q, err_d;

   assign sp_m1     = sp_q - SPW'(1);
   assign stack_err = err_q;
`else
   // Depth only sizes the optional stack; referenced here so the default build stays tidy.
   localparam logic [STACK_DEPTH-1:0] DEPTH_UNUSED = '0;
`endif

   assign pc_inc  = pc_q + ADDR_WIDTH'(1);
   assign z_flag  = (acc == '0);
   assign pz_flag = ~acc[DATA_WIDTH-1];
   assign pc      = pc_q;
   assign taken   = taken_q;
   assign wrap    = wrap_q;
   assign running = (state_q == RUN);
   assign halted  = (state_q == HALT);

   // Next state: clear wins, then per-state behaviour; taken/wrap are one-cycle pulses.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      taken_d = 1'b0;
      wrap_d  = 1'b0;
`ifdef LMC_CALL_STACK_EN
      stk_d   = stk_q;
      sp_d    = sp_q;
      err_d   = err_q;
`endif
      if (clear) begin
         state_d = IDLE;
         pc_d    = '0;
`ifdef LMC_CALL_STACK_EN
         sp_d    = '0;
         err_d   = 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: state_d = run ? RUN : IDLE;
            RUN: begin
               if (!run) begin
                  state_d = IDLE;
               end else if (step) begin
                  if (halt_req) begin
                     state_d = HALT;
                  end
`ifdef LMC_CALL_STACK_EN
                  else if (call) begin
                     if (sp_q == FULL) begin
                        err_d   = 1'b1;
                        state_d = HALT;
                     end else begin
                        stk_d[sp_q[IW-1:0]] = pc_inc;
                        sp_d    = sp_q + SPW'(1);
                        pc_d    = target;
                        taken_d = 1'b1;
                     end
                  end else if (ret) begin
                     if (sp_q == '0) begin
                        err_d   = 1'b1;
                        state_d = HALT;
                     end else begin
                        pc_d    = stk_q[sp_m1[IW-1:0]];
                        sp_d    = sp_m1;
                        taken_d = 1'b1;
                     end
                  end
`endif
                  else if (jmp || (z_jmp && z_flag) || (pz_jmp && pz_flag)) begin
                     pc_d    = target;
                     taken_d = 1'b1;
                  end else begin
                     pc_d   = pc_inc;
                     wrap_d = &pc_q;
                  end
               end
            end
            default: state_d = HALT;
         endcase
      end
   end

   // State and PC registers, asynchronously cleared.
   always_ff @(posedge timer555 or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         pc_q    <= '0;
         taken_q <= 1'b0;
         wrap_q  <= 1'b0;
`ifdef LMC_CALL_STACK_EN
         stk_q   <= '{default: '0};
         sp_q    <= '0;
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         taken_q <= taken_d;
         wrap_q  <= wrap_d;
`ifdef LMC_CALL_STACK_EN
         stk_q   <= stk_d;
         sp_q    <= sp_d;
         err_q   <= err_d;
`endif
      end
   end

endmodule

// File: tb/tb_lmc_pc_branch.sv
// tb_lmc_pc_branch: directed scoreboard bench for lmc_pc_branch (default parameters).
module tb_lmc_pc_branch;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       clear = 1'b0, run = 1'b0, step = 1'b0, halt_req = 1'b0;
   logic       jmp = 1'b0, z_jmp = 1'b0, pz_jmp = 1'b0;
   logic [3:0] target = '0;
   logic [7:0] acc = '0;
   logic       call = 1'b0, ret = 1'b0, stack_err;
   logic [3:0] pc;
   logic       z_flag, pz_flag, taken, wrap, running, halted;
   logic       er_exp = 1'b0;

   int tests = 0;
   int fails = 0;

   typedef struct {
      string      nm;
      logic [3:0] pc;
      logic       tk, wr, ru, ha, z, pz, er;
   } exp_t;

   exp_t q[$];

   localparam logic [1:0] I = 2'd0, R = 2'd1, H = 2'd2;

   lmc_pc_branch dut (
      .timer555 (clk),
      .reset_n  (reset_n),
      .clear    (clear),
      .run      (run),
      .step     (step),
      .halt_req (halt_req),
      .jmp      (jmp),
      .z_jmp    (z_jmp),
      .pz_jmp   (pz_jmp),
      .target   (target),
      .acc      (acc),
`ifdef LMC_CALL_STACK_EN
      .call     (call),
      .ret      (ret),
      .stack_err(stack_err),
`endif
      .pc       (pc),
      .z_flag   (z_flag),
      .pz_flag  (pz_flag),
      .taken    (taken),
      .wrap     (wrap),
      .running  (running),
      .halted   (halted)
   );

`ifndef LMC_CALL_STACK_EN
   assign stack_err = 1'b0;
`endif

   always #5 clk = ~clk;

   task automatic cmp(string nm, string fld, int act, int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s.%s: got %0d, expected %0d", nm, fld, act, exp);
      end
   endtask

   // Monitor: every negedge, compare DUT outputs against the oldest expectation.
   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         cmp(e.nm, "pc", int'(pc), int'(e.pc));
         cmp(e.nm, "taken", int'(taken), int'(e.tk));
         cmp(e.nm, "wrap", int'(wrap), int'(e.wr));
         cmp(e.nm, "running", int'(running), int'(e.ru));
         cmp(e.nm, "halted", int'(halted), int'(e.ha));
         cmp(e.nm, "z_flag", int'(z_flag), int'(e.z));
         cmp(e.nm, "pz_flag", int'(pz_flag), int'(e.pz));
`ifdef LMC_CALL_STACK_EN
         cmp(e.nm, "stack_err", int'(stack_err), int'(e.er));
`endif
      end
   end

   function automatic exp_t mk(string nm, logic [3:0] p, logic tk, logic wr, logic [1:0] st);
      exp_t e;
      e.nm = nm;
      e.pc = p;
      e.tk = tk;
      e.wr = wr;
      e.ru = (st == R);
      e.ha = (st == H);
      e.z  = (acc == 8'h00);
      e.pz = (acc < 8'h80);
      e.er = er_exp;
      return e;
   endfunction

   // Inputs are already driven; queue what the outputs must be after the next edge.
   task automatic chk(string nm, logic [3:0] p, logic tk, logic wr, logic [1:0] st);
      q.push_back(mk(nm, p, tk, wr, st));
      @(negedge clk);
      #1;
   endtask

   task automatic quiet();
      step = 1'b0; halt_req = 1'b0; jmp = 1'b0; z_jmp = 1'b0; pz_jmp = 1'b0;
      clear = 1'b0; call = 1'b0; ret = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      @(negedge clk);
      #1;
      chk("reset", 4'd0, 0, 0, I);
      reset_n = 1'b1;
      run = 1'b1; step = 1'b1; jmp = 1'b1; target = 4'd9; acc = 8'd1;
      chk("idle_ign", 4'd0, 0, 0, R);
      jmp = 1'b0;
      for (int i = 1; i <= 5; i++) chk("inc", 4'(i), 0, 0, R);
      // Asynchronous reset asserted just after a rising edge, checked before the next one.
      step = 1'b0;
      @(posedge clk);
      #1;
      reset_n = 1'b0;
      q.push_back(mk("async_rst", 4'd0, 0, 0, I));
      @(negedge clk);
      #1;
      reset_n = 1'b1;
      chk("resume", 4'd0, 0, 0, R);
      step = 1'b1;
      for (int i = 1; i <= 3; i++) chk("start", 4'(i), 0, 0, R);
      acc = 8'h00; z_jmp = 1'b1; target = 4'd9;
      chk("z_taken", 4'd9, 1, 0, R);
      z_jmp = 1'b0; acc = 8'h80; pz_jmp = 1'b1; target = 4'd3;
      chk("pz_not", 4'd10, 0, 0, R);
      acc = 8'h05; target = 4'd14;
      chk("pz_taken", 4'd14, 1, 0, R);
      pz_jmp = 1'b0; acc = 8'h01;
      chk("inc15", 4'd15, 0, 0, R);
      chk("wrap", 4'd0, 0, 1, R);
      step = 1'b0;
      chk("hold", 4'd0, 0, 0, R);
      step = 1'b1;
      chk("inc1", 4'd1, 0, 0, R);
      acc = 8'h03; z_jmp = 1'b1; target = 4'd5;
      chk("z_not", 4'd2, 0, 0, R);
      z_jmp = 1'b0; jmp = 1'b1; target = 4'd0;
      chk("jmp0", 4'd0, 1, 0, R);
      z_jmp = 1'b1; acc = 8'h00; target = 4'd7;
      chk("prio", 4'd7, 1, 0, R);
      z_jmp = 1'b0; run = 1'b0; target = 4'd2;
      chk("pause", 4'd7, 0, 0, I);
      for (int i = 0; i < 10; i++) chk("paused", 4'd7, 0, 0, I);
      quiet(); run = 1'b1; acc = 8'h01;
      chk("unpause", 4'd7, 0, 0, R);
      step = 1'b1;
      chk("inc8", 4'd8, 0, 0, R);
      halt_req = 1'b1; jmp = 1'b1; target = 4'd2;
      chk("halt", 4'd8, 0, 0, H);
      halt_req = 1'b0;
      for (int i = 0; i < 5; i++) chk("frozen", 4'd8, 0, 0, H);
      quiet(); clear = 1'b1;
      chk("clear", 4'd0, 0, 0, I);
      clear = 1'b0;
      chk("rerun", 4'd0, 0, 0, R);
      step = 1'b1;
      chk("rerun_inc", 4'd1, 0, 0, R);
      clear = 1'b1; jmp = 1'b1; target = 4'd5;
      chk("clr_run", 4'd0, 0, 0, I);
      quiet();
`ifdef LMC_CALL_STACK_EN
      chk("s_go", 4'd0, 0, 0, R);
      step = 1'b1;
      chk("s_inc", 4'd1, 0, 0, R);
      chk("s_inc", 4'd2, 0, 0, R);
      call = 1'b1; target = 4'd8;
      chk("call", 4'd8, 1, 0, R);
      call = 1'b0; ret = 1'b1;
      chk("ret", 4'd3, 1, 0, R);
      ret = 1'b0; call = 1'b1; target = 4'd4;
      for (int i = 0; i < 4; i++) chk("nest", 4'd4, 1, 0, R);
      er_exp = 1'b1;
      chk("overflow", 4'd4, 0, 0, H);
      quiet(); clear = 1'b1; er_exp = 1'b0;
      chk("clr_stk", 4'd0, 0, 0, I);
      clear = 1'b0;
      chk("s_go2", 4'd0, 0, 0, R);
      step = 1'b1; ret = 1'b1; er_exp = 1'b1;
      chk("underflow", 4'd0, 0, 0, H);
      quiet();
`endif
      @(negedge clk);
      cmp("drain", "pending", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/lmc_pc_branch.md
Name: lmc_pc_branch

Overview:
- Parametrised program-counter and branch unit for the next-generation LMC core.
- Replaces the fixed 2-bit address / 4-bit data control path.
- Holds PC and a run/halt state machine. Resolves unconditional, zero and positive-or-zero branches against the accumulator.
- Sits between the instruction decoder (strobes, target) and the RAM address mux.

Parameters:
- ADDR_WIDTH, 4, PC / branch-target width; program space is 2^ADDR_WIDTH words.
- DATA_WIDTH, 8, accumulator width; two's complement, MSB is sign.
- STACK_DEPTH, 4, return-stack entries; used only with LMC_CALL_STACK_EN.

Ports:
- timer555  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous restart: PC to 0, state to IDLE.
- run  in  1  level; 1 = execute, 0 = pause.
- step  in  1  one instruction completes this cycle; PC update allowed.
- halt_req  in  1  HLT instruction decoded.
- jmp  in  1  unconditional branch strobe.
- z_jmp  in  1  branch if acc == 0.
- pz_jmp  in  1  branch if acc >= 0 (MSB == 0).
- target  in  ADDR_WIDTH  branch destination.
- acc  in  DATA_WIDTH  current accumulator value.
- pc  out  ADDR_WIDTH  registered program counter.
- z_flag  out  1  combinational, acc == 0.
- pz_flag  out  1  combinational, acc[DATA_WIDTH-1] == 0.
- taken  out  1  registered 1-cycle pulse: branch taken on the previous update.
- wrap  out  1  registered 1-cycle pulse: PC incremented from max to 0.
- running  out  1  state == RUN.
- halted  out  1  state == HALT.

Behaviour:
- Reset (reset_n=0, asynchronous): pc=0, state=IDLE, taken=0, wrap=0, running=0, halted=0. Release is synchronous to the next timer555 edge.
- States: IDLE, RUN, HALT. All transitions on the rising edge of timer555.
- clear=1 has top priority in every state: next pc=0, state=IDLE, taken=0, wrap=0.
- IDLE: run=1 → RUN. pc holds. step and branch strobes are ignored.
- RUN, run=0: → IDLE (pause). pc is held and resumes on the next run=1.
- RUN, run=1, step=0: everything holds. taken and wrap clear to 0.
- RUN, run=1, step=1: priority is halt_req > jmp > (z_jmp & z_flag) > (pz_jmp & pz_flag) > increment.
  - halt_req: state → HALT, pc unchanged, taken=0.
  - Branch taken: pc ← target, taken=1 next cycle.
  - Conditional strobe with false condition: treated as increment, taken=0.
  - Increment: pc ← pc+1 modulo 2^ADDR_WIDTH. wrap=1 when old pc was all ones.
  - A branch to address 0 never sets wrap.
- HALT: pc frozen. run, step and strobes are ignored. Exit only via clear or reset_n.
- Flags are purely combinational from acc, with zero latency. Branch decisions use the acc value present in the step cycle.
- pc latency: the new value is visible one cycle after the step cycle.
- Several conditional strobes asserted together resolve by the priority above, with no error.

Optional Feature:
- Macro LMC_CALL_STACK_EN.
- Defined:
  - Adds inputs call and ret (1 bit each) and output stack_err (1 bit, sticky, cleared by clear or reset).
  - Return stack is STACK_DEPTH × ADDR_WIDTH.
  - Priority inside the step cycle: halt_req > call > ret > jmp > conditionals.
  - call: push pc+1 (modulo), pc ← target, taken=1.
  - ret: pop into pc, taken=1.
  - Push when full, or pop when empty: stack_err=1, state → HALT, pc unchanged.
  - clear and reset empty the stack.
- Undefined: those ports and the stack do not exist; behaviour is exactly as above.

Test Plan:
- Reset/start: reset_n low mid-run with pc=5 → pc=0, IDLE immediately (async). Then run=1, step=1 for 3 cycles → pc 0,1,2,3.
- Wrap: ADDR_WIDTH=4, run from pc=14 with steps → pc 15, then 0 with wrap=1 for exactly one cycle. A jmp to target=0 → wrap stays 0.
- Conditionals: acc=0x00, z_jmp=1, target=9 → pc=9, taken=1. acc=0x80, pz_jmp=1, target=3 → no branch, pc+1, pz_flag=0. acc=0x05, pz_jmp=1 → branch taken.
- Priority/simultaneous: jmp=1, z_jmp=1, acc=0, targets differ only via the single target bus → pc=target, taken=1. halt_req with jmp → HALT, pc unchanged.
- Pause/halt: run=0 in RUN at pc=7 → IDLE, pc=7 held over 10 cycles of step=1. After HALT, run/step for 5 cycles → pc frozen. clear → pc=0, IDLE.
- LMC_CALL_STACK_EN, STACK_DEPTH=4: call from pc=2 to target=8 → pc=8. ret → pc=3. Five nested calls → stack_err=1, HALT. ret on empty stack after clear → stack_err=1.
